// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-style control FSM. Decodes state/Inst/MIO_ready
// into datapath controls. Optional overflow trap: define OVF_TRAP_EN.
//
// Ports:
//   clk, reset (async active-low)         - clock and reset
//   Inst[31:0]                            - instruction register contents
//   MIO_ready, zero, overflow             - memory ready, ALU flags
//   IorD, IRWrite, RegWrite, PCWrite,
//   PCWriteCond, BNE                      - datapath enables
//   RegDst, MemtoReg, ALUSrcA, PCSource   - 2-bit mux selects
//   ALUSrcB[2:0], ALU_operation[3:0]      - ALU operand select / opcode
//   mem_rd, mem_w                         - memory strobes
//   illegal                               - unsupported opcode/funct pulse
//   ovf_trap                              - overflow trap pulse (0 if disabled)
//   state[4:0]                            - current state for debug
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst,
    input  logic        MIO_ready,
    input  logic        zero,
    input  logic        overflow,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        BNE,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALUSrcB,
    output logic [3:0]  ALU_operation,
    output logic        mem_rd,
    output logic        mem_w,
    output logic        illegal,
    output logic        ovf_trap,
    output logic [4:0]  state
);

    typedef enum logic [4:0] {
        S_IF    = 5'd0,
        S_ID    = 5'd1,
        S_MADDR = 5'd2,
        S_MRD   = 5'd3,
        S_LWWB  = 5'd4,
        S_MWR   = 5'd5,
        S_REXE  = 5'd6,
        S_RWB   = 5'd7,
        S_BR    = 5'd8,
        S_J     = 5'd9,
        S_JAL   = 5'd10,
        S_JR    = 5'd11,
        S_IEXE  = 5'd12,
        S_IWB   = 5'd13,
        S_LUIWB = 5'd14
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_ovf;

    assign w_op  = Inst[31:26];
    assign w_fn  = Inst[5:0];
    assign state = r_state;

`ifdef OVF_TRAP_EN
    logic r_ovf;
    logic w_unused;

    assign w_unused = ^{zero, Inst[25:6]};
    assign w_ovf    = r_ovf;

    // Overflow is sampled only by signed-add/sub executes; the
    // writeback that follows suppresses the register write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IF: r_ovf <= 1'b0;
                S_REXE: begin
                    if (w_fn == FN_ADD || w_fn == FN_SUB)
                        r_ovf <= overflow;
                end
                S_IEXE: begin
                    if (w_op == OP_ADDI)
                        r_ovf <= overflow;
                end
                default: r_ovf <= r_ovf;
            endcase
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{zero, overflow, Inst[25:6]};
    assign w_ovf    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IF;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = S_IF;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        BNE           = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcA       = 2'b00;
        PCSource      = 2'b00;
        ALUSrcB       = 3'b000;
        ALU_operation = ALU_AND;
        mem_rd        = 1'b0;
        mem_w         = 1'b0;
        illegal       = 1'b0;
        ovf_trap      = 1'b0;

        case (r_state)
            S_IF: begin
                mem_rd        = 1'b1;
                IRWrite       = MIO_ready;
                ALUSrcB       = 3'b001;
                ALU_operation = ALU_ADD;
                PCWrite       = 1'b1;
                w_next        = MIO_ready ? S_ID : S_IF;
            end
            S_ID: begin
                // Precompute the branch target into ALUOut.
                ALUSrcB       = 3'b011;
                ALU_operation = ALU_ADD;
                case (w_op)
                    OP_LW, OP_SW:
                        w_next = S_MADDR;
                    OP_RTYPE:
                        w_next = (w_fn == FN_JR) ? S_JR : S_REXE;
                    OP_BEQ, OP_BNE:
                        w_next = S_BR;
                    OP_J:
                        w_next = S_J;
                    OP_JAL:
                        w_next = S_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:
                        w_next = S_IEXE;
                    OP_LUI:
                        w_next = S_LUIWB;
                    default: begin
                        w_next  = S_IF;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MADDR: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 3'b010;
                ALU_operation = ALU_ADD;
                w_next        = (w_op == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                IorD   = 1'b1;
                mem_rd = 1'b1;
                w_next = MIO_ready ? S_LWWB : S_MRD;
            end
            S_MWR: begin
                IorD   = 1'b1;
                mem_w  = 1'b1;
                w_next = MIO_ready ? S_IF : S_MWR;
            end
            S_LWWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
                w_next   = S_IF;
            end
            S_REXE: begin
                ALUSrcA = 2'b01;
                w_next  = S_RWB;
                case (w_fn)
                    FN_ADD: ALU_operation = ALU_ADD;
                    FN_SUB: ALU_operation = ALU_SUB;
                    FN_AND: ALU_operation = ALU_AND;
                    FN_OR:  ALU_operation = ALU_OR;
                    FN_XOR: ALU_operation = ALU_XOR;
                    FN_NOR: ALU_operation = ALU_NOR;
                    FN_SLT: ALU_operation = ALU_SLT;
                    default: begin
                        w_next  = S_IF;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_RWB: begin
                RegDst   = 2'b01;
                RegWrite = ~w_ovf;
                ovf_trap = w_ovf;
                w_next   = S_IF;
            end
            S_BR: begin
                ALUSrcA       = 2'b01;
                ALU_operation = ALU_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = 2'b01;
                // Opcode bit 0 distinguishes bne from beq.
                BNE           = Inst[26];
                w_next        = S_IF;
            end
            S_J: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                w_next   = S_IF;
            end
            S_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
                RegWrite = 1'b1;
                w_next   = S_IF;
            end
            S_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
                w_next   = S_IF;
            end
            S_IEXE: begin
                ALUSrcA = 2'b01;
                w_next  = S_IWB;
                case (w_op)
                    OP_ADDI: begin
                        ALU_operation = ALU_ADD;
                        ALUSrcB       = 3'b010;
                    end
                    OP_SLTI: begin
                        ALU_operation = ALU_SLT;
                        ALUSrcB       = 3'b010;
                    end
                    OP_ANDI: begin
                        ALU_operation = ALU_AND;
                        ALUSrcB       = 3'b100;
                    end
                    OP_ORI: begin
                        ALU_operation = ALU_OR;
                        ALUSrcB       = 3'b100;
                    end
                    OP_XORI: begin
                        ALU_operation = ALU_XOR;
                        ALUSrcB       = 3'b100;
                    end
                    default: begin
                        ALU_operation = ALU_AND;
                        ALUSrcB       = 3'b000;
                    end
                endcase
            end
            S_IWB: begin
                RegWrite = ~w_ovf;
                ovf_trap = w_ovf;
                w_next   = S_IF;
            end
            S_LUIWB: begin
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
                w_next   = S_IF;
            end
            default: w_next = S_IF;
        endcase
    end

endmodule
